// File: rtl/cc_membus_pkg.sv
// cc_membus_pkg -- shared types and defaults for the memory-bus writeback
// controller.
//   state_e          : controller FSM states
//   DATAWIDTH_DEF    : default data bus width
//   ADDRWIDTH_DEF    : default address width
//   TIMEOUT_DEF      : default memory-ack timeout in cycles (2..255)
//   TIMEOUT_CNT_W    : counter width able to hold any legal timeout
package cc_membus_pkg;

  localparam int DATAWIDTH_DEF = 32;
  localparam int ADDRWIDTH_DEF = 32;
  localparam int TIMEOUT_DEF   = 16;
  localparam int TIMEOUT_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ALU_WB  = 3'd1,
    MEM_REQ = 3'd2,
    MEM_WB  = 3'd3,
    ERR     = 3'd4
  } state_e;

endpackage

// File: rtl/cc_membus_timeout_cnt.sv
// cc_membus_timeout_cnt -- counts consecutive cycles spent waiting for a
// memory ack and flags the last cycle of the allowed window.
// Only instantiated when CC_MEMBUS_TIMEOUT_EN is defined.
// Ports:
//   gclk       in  clock, rising edge
//   grst_n     in  asynchronous reset, active-low
//   en_i       in  1 while the controller is waiting in MEM_REQ
//   expired_o  out 1 during the final counted cycle (cycle TIMEOUT_CYCLES)
module cc_membus_timeout_cnt
  import cc_membus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic en_i,
  output logic expired_o
);

  logic [TIMEOUT_CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of wait cycles already completed, so it reads 0
  // in the first MEM_REQ cycle; leaving MEM_REQ clears it for the next load.
  always_comb begin
    cnt_d = '0;
    if (en_i) cnt_d = cnt_q + TIMEOUT_CNT_W'(1);
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expired_o = en_i && (cnt_q == TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cc_membus_controller.sv
// cc_membus_controller -- sequences ALU-result and memory-load writebacks
// into the register file, one operation at a time.
// Optional feature: define CC_MEMBUS_TIMEOUT_EN to abort a load that gets
// no mem_ack within TIMEOUT_CYCLES cycles (one-cycle timeout_err pulse).
// Ports:
//   CC_MEMBUS_CONTROLLER_CLOCK_50     in  clock, rising edge
//   CC_MEMBUS_CONTROLLER_RESET_InLow  in  async reset, active-low
//   op_valid/op_ready                 op handshake (ready only in IDLE)
//   op_is_load/op_addr/op_rd_index    operation kind, load address, dest reg
//   mem_rd_req/mem_addr               read request to main memory
//   mem_ack/mem_data_in               memory data return
//   mem_data_out                      latched load data for the external mux
//   mux_rd_sel                        external mux select (1 = memory)
//   wb_en/wb_index                    register-file write strobe and index
//   timeout_err                       one-cycle timeout pulse
module cc_membus_controller
  import cc_membus_pkg::*;
#(
  parameter int DATAWIDTH_BUS  = DATAWIDTH_DEF,
  parameter int ADDRWIDTH_BUS  = ADDRWIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                     CC_MEMBUS_CONTROLLER_CLOCK_50,
  input  logic                     CC_MEMBUS_CONTROLLER_RESET_InLow,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic                     op_is_load,
  input  logic [ADDRWIDTH_BUS-1:0] op_addr,
  input  logic [4:0]               op_rd_index,
  output logic                     mem_rd_req,
  output logic [ADDRWIDTH_BUS-1:0] mem_addr,
  input  logic                     mem_ack,
  input  logic [DATAWIDTH_BUS-1:0] mem_data_in,
  output logic [DATAWIDTH_BUS-1:0] mem_data_out,
  output logic                     mux_rd_sel,
  output logic                     wb_en,
  output logic [4:0]               wb_index,
  output logic                     timeout_err
);

  logic clk, rst_n;
  assign clk   = CC_MEMBUS_CONTROLLER_CLOCK_50;
  assign rst_n = CC_MEMBUS_CONTROLLER_RESET_InLow;

  state_e                   state_q, state_d;
  logic [ADDRWIDTH_BUS-1:0] addr_q, addr_d;
  logic [4:0]               rd_q, rd_d;
  logic [DATAWIDTH_BUS-1:0] data_q, data_d;
  logic                     timeout_hit;

`ifdef CC_MEMBUS_TIMEOUT_EN
  cc_membus_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .gclk      (clk),
    .grst_n    (rst_n),
    .en_i      (state_q == MEM_REQ),
    .expired_o (timeout_hit)
  );
  assign timeout_err = (state_q == ERR);
`else
  // Without the timeout option a load waits for its ack indefinitely.
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Gated by reset so every output, including op_ready, reads 0 while reset
  // is held and ready rises as soon as reset releases.
  assign op_ready = rst_n && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (op_valid && op_ready) begin
          addr_d  = op_addr;
          rd_d    = op_rd_index;
          state_d = op_is_load ? MEM_REQ : ALU_WB;
        end
      end
      ALU_WB: state_d = IDLE;
      MEM_REQ: begin
        // An ack in the final counted cycle is checked first, so it wins.
        if (mem_ack) begin
          data_d  = mem_data_in;
          state_d = MEM_WB;
        end else if (timeout_hit) begin
          state_d = ERR;
        end
      end
      MEM_WB:  state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  assign mem_rd_req   = (state_q == MEM_REQ);
  assign mem_addr     = addr_q;
  assign mem_data_out = data_q;
  assign mux_rd_sel   = (state_q == MEM_WB);
  assign wb_en        = (state_q == ALU_WB) || (state_q == MEM_WB);
  assign wb_index     = rd_q;

endmodule

// File: tb/tb_cc_membus_controller.sv
// tb_cc_membus_controller -- randomized scoreboard bench for
// cc_membus_controller. Build with CC_MEMBUS_TIMEOUT_EN defined to exercise
// the timeout path (the bench then uses TIMEOUT_CYCLES = 4).
module tb_cc_membus_controller;

`ifdef CC_MEMBUS_TIMEOUT_EN
  localparam int TOC   = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TOC   = 16;
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0, op_is_load = 1'b0, mem_ack = 1'b0;
  logic [31:0] op_addr = '0, mem_data_in = '0;
  logic [4:0]  op_rd_index = '0;
  logic        op_ready, mem_rd_req, mux_rd_sel, wb_en, timeout_err;
  logic [31:0] mem_addr, mem_data_out;
  logic [4:0]  wb_index;

  cc_membus_controller #(
    .DATAWIDTH_BUS(32), .ADDRWIDTH_BUS(32), .TIMEOUT_CYCLES(TOC)
  ) dut (
    .CC_MEMBUS_CONTROLLER_CLOCK_50   (clk),
    .CC_MEMBUS_CONTROLLER_RESET_InLow(rst_n),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_is_load  (op_is_load),
    .op_addr     (op_addr),
    .op_rd_index (op_rd_index),
    .mem_rd_req  (mem_rd_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data_in (mem_data_in),
    .mem_data_out(mem_data_out),
    .mux_rd_sel  (mux_rd_sel),
    .wb_en       (wb_en),
    .wb_index    (wb_index),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected observable outcome of one operation.
  typedef struct {
    int          cyc;    // cycle (cyc value) in which it is visible
    bit          err;    // timeout pulse instead of a writeback
    bit          is_mem; // memory writeback vs ALU writeback
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0, n_fail = 0;
  logic [31:0] last_data = '0; // what mem_data_out should currently hold

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: whenever the DUT presents a writeback or a timeout, pop the
  // oldest expectation and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (wb_en || timeout_err) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {30'd0, wb_en, timeout_err}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("out_cycle", cyc, e.cyc);
          chk("timeout_err", timeout_err, e.err);
          chk("wb_en", wb_en, !e.err);
          chk("mux_rd_sel", mux_rd_sel, e.is_mem);
          if (!e.err) chk("wb_index", wb_index, e.rd);
          if (e.is_mem) chk("mem_data_out", mem_data_out, e.data);
        end
      end else begin
        chk("mux_idle", mux_rd_sel, 1'b0);
      end
    end
  end

  // One operation. d = MEM_REQ cycle (1-based) in which mem_ack is shown;
  // gap = idle cycles afterwards, each with a random spurious ack.
  task automatic do_op(input bit ld, input logic [31:0] addr, input logic [4:0] rd,
                       input int d, input logic [31:0] data, input int gap);
    exp_t e;
    int   n;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("data_hold", mem_data_out, last_data);
    chk("op_ready_idle", op_ready, 1'b1);
    op_valid = 1'b1; op_is_load = ld; op_addr = addr; op_rd_index = rd;
    e.rd = rd; e.data = data; e.is_mem = 1'b0; e.err = 1'b0;
    n = d;
    if (!ld) e.cyc = cyc + 1;
    else if (TO_EN && d > TOC) begin
      e.err = 1'b1; e.cyc = cyc + 1 + TOC; n = TOC;
    end else begin
      e.is_mem = 1'b1; e.cyc = cyc + 1 + d;
    end
    sb.push_back(e);
    @(negedge clk);
    if (!ld) begin
      // op_valid stays high through the writeback cycle: no second accept.
      chk("op_ready_busy", op_ready, 1'b0);
      @(negedge clk);
      op_valid = 1'b0;
    end else begin
      op_valid = 1'b0;
      for (int k = 1; k <= n; k++) begin
        if (k > 1) @(negedge clk);
        chk("mem_rd_req", mem_rd_req, 1'b1);
        chk("mem_addr", mem_addr, addr);
        chk("op_ready_req", op_ready, 1'b0);
        if (k == d) begin mem_ack = 1'b1; mem_data_in = data; end
      end
      @(negedge clk);
      mem_ack = 1'b0;
      chk("mem_rd_req_drop", mem_rd_req, 1'b0);
      if (!e.err) last_data = data;
      @(negedge clk);
    end
    for (int g = 0; g < gap; g++) begin
      mem_ack = 1'($urandom); mem_data_in = $urandom;
      @(negedge clk);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_op_ready"}, op_ready, 1'b0);
    chk({tag, "_mem_rd_req"}, mem_rd_req, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_data_out"}, mem_data_out, 32'd0);
    chk({tag, "_mux_rd_sel"}, mux_rd_sel, 1'b0);
    chk({tag, "_wb_en"}, wb_en, 1'b0);
    chk({tag, "_wb_index"}, wb_index, 5'd0);
    chk({tag, "_timeout_err"}, timeout_err, 1'b0);
  endtask

  initial begin
    exp_t e;
    int   wait_cyc;
    #22;
    chk_all_zero("reset");
    // Release away from a clock edge; first op is offered right away.
    @(negedge clk); #1 rst_n = 1'b1;
    #1 chk("op_ready_after_reset", op_ready, 1'b1);

    // Directed: ALU op rd=5, load 0x100 with ack in 3rd cycle, same-cycle ack.
    do_op(1'b0, 32'h0, 5'd5, 0, 32'h0, 0);
    do_op(1'b1, 32'h100, 5'd9, 3, 32'hDEADBEEF, 2);
    do_op(1'b1, 32'h104, 5'd3, 1, 32'h12345678, 1);
    // Ack exactly in the last counted cycle, then a long wait (timeout when
    // enabled, indefinite wait otherwise).
    do_op(1'b1, 32'h200, 5'd7, TOC, 32'hA5A5A5A5, 0);
    do_op(1'b1, 32'h300, 5'd8, TOC + 3, 32'hCAFEF00D, 1);

    // Randomized traffic.
    for (int i = 0; i < 60; i++)
      do_op(1'($urandom), $urandom, 5'($urandom), int'($urandom_range(1, TOC + 2)),
            $urandom, int'($urandom_range(0, 2)));

    // Reset in the middle of MEM_REQ: no writeback, stale ack ignored.
    @(negedge clk);
    mem_ack = 1'b0;
    op_valid = 1'b1; op_is_load = 1'b1; op_addr = 32'h400; op_rd_index = 5'd11;
    @(negedge clk); op_valid = 1'b0;
    @(negedge clk);
    chk("mem_rd_req_pre_reset", mem_rd_req, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreq_reset");
    last_data = '0;
    @(negedge clk); mem_ack = 1'b1; mem_data_in = 32'hBADBAD00;
    @(posedge clk); #2 rst_n = 1'b1;
    #1 chk("op_ready_release", op_ready, 1'b1);
    @(negedge clk);
    chk("stale_ack_data", mem_data_out, 32'd0);
    chk("stale_ack_req", mem_rd_req, 1'b0);
    do_op(1'b0, 32'h0, 5'd12, 0, 32'h0, 0);

    // Acceptance on the very first edge after reset release.
    @(negedge clk); rst_n = 1'b0;
    #1 rst_n = 1'b1;
    op_valid = 1'b1; op_is_load = 1'b0; op_rd_index = 5'd21; mem_ack = 1'b0;
    e.cyc = cyc + 1; e.err = 1'b0; e.is_mem = 1'b0; e.rd = 5'd21; e.data = '0;
    sb.push_back(e);
    @(negedge clk); @(negedge clk); op_valid = 1'b0;

    // Drain with a bounded wait.
    wait_cyc = 0;
    while (sb.size() != 0 && wait_cyc < 50) begin @(negedge clk); wait_cyc++; end
    chk("scoreboard_drained", sb.size(), 0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cc_membus_controller.md
CC_MEMBUS_CONTROLLER -- requirements
Module: cc_membus_controller

Interface
REQ-001 Parameter DATAWIDTH_BUS, default 32, SHALL set the data bus width.
REQ-002 Parameter ADDRWIDTH_BUS, default 32, SHALL set the address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, range 2..255, SHALL set the memory-ack timeout in cycles.
REQ-004 The block SHALL use one clock, CC_MEMBUS_CONTROLLER_CLOCK_50; reset CC_MEMBUS_CONTROLLER_RESET_InLow SHALL be asynchronous and active-low.
REQ-005 The ports SHALL be as follows (name  direction  width  meaning):
- CC_MEMBUS_CONTROLLER_CLOCK_50  in  1  clock, rising edge.
- CC_MEMBUS_CONTROLLER_RESET_InLow  in  1  asynchronous reset, active-low.
- op_valid  in  1  operation offered.
- op_ready  out  1  controller can accept an operation.
- op_is_load  in  1  1 = memory load, 0 = ALU result writeback.
- op_addr  in  ADDRWIDTH_BUS  load address.
- op_rd_index  in  5  destination register index.
- mem_rd_req  out  1  read request to main memory.
- mem_addr  out  ADDRWIDTH_BUS  read address.
- mem_ack  in  1  memory data valid.
- mem_data_in  in  DATAWIDTH_BUS  memory read data.
- mem_data_out  out  DATAWIDTH_BUS  latched load data, feeding the mux memory input.
- mux_rd_sel  out  1  writeback mux select: 1 = memory, 0 = ALU.
- wb_en  out  1  register-file write strobe.
- wb_index  out  5  register-file write index.
- timeout_err  out  1  one-cycle timeout pulse.

Function
REQ-006 The FSM SHALL have exactly these states: IDLE, ALU_WB, MEM_REQ, MEM_WB, ERR.
REQ-007 op_ready SHALL be 1 only in IDLE; an operation SHALL be accepted on a rising edge where op_valid && op_ready.
REQ-008 On acceptance, op_addr and op_rd_index SHALL be registered; the next state SHALL be MEM_REQ if op_is_load=1, else ALU_WB.
REQ-009 ALU_WB SHALL last one cycle with wb_en=1 and mux_rd_sel=0, then return to IDLE; ALU latency SHALL be acceptance edge + 1 cycle.
REQ-010 In MEM_REQ, mem_rd_req SHALL be held at 1 and mem_addr SHALL be held at the registered address until mem_ack is sampled at 1.
REQ-011 An ack sampled in the first MEM_REQ cycle SHALL be valid.
REQ-012 When mem_ack is sampled at 1 in MEM_REQ, mem_data_in SHALL be latched into mem_data_out and the next state SHALL be MEM_WB.
REQ-013 MEM_WB SHALL last one cycle with mux_rd_sel=1 and wb_en=1, then return to IDLE; load writeback SHALL occur in the cycle after the ack edge.
REQ-014 mem_ack outside MEM_REQ SHALL be ignored, with no state or data change.
REQ-015 mux_rd_sel SHALL be 0 in every state except MEM_WB.
REQ-016 wb_index SHALL equal the registered op_rd_index whenever wb_en=1.
REQ-017 mem_data_out SHALL hold its value until the next ack.
REQ-018 No back-to-back overlap: a new operation SHALL be accepted only after return to IDLE, so the minimum issue interval SHALL be 2 cycles.

Reset
REQ-019 Reset assertion SHALL force IDLE immediately, independent of the clock.
REQ-020 During reset, every output SHALL be 0 except op_ready, which SHALL be 1 once reset releases into IDLE.
REQ-021 Reset during MEM_REQ SHALL drop mem_rd_req without writeback, and a later stale ack SHALL be ignored.
REQ-022 The first acceptance SHALL be possible on the first rising edge after deassertion.

Configuration
REQ-023 With macro CC_MEMBUS_TIMEOUT_EN defined, a cycle counter SHALL run in MEM_REQ.
REQ-024 With CC_MEMBUS_TIMEOUT_EN defined, if no ack arrives within TIMEOUT_CYCLES cycles the FSM SHALL go to ERR.
REQ-025 ERR SHALL last one cycle with timeout_err=1, wb_en=0 and mem_rd_req=0, then return to IDLE.
REQ-026 With CC_MEMBUS_TIMEOUT_EN defined, an ack in the final counted cycle SHALL win over the timeout.
REQ-027 Without CC_MEMBUS_TIMEOUT_EN, MEM_REQ SHALL wait indefinitely, ERR SHALL be unreachable, and timeout_err SHALL be tied to 0 with the port retained.

Structure
REQ-028 Package cc_membus_pkg SHALL hold the state enum and the default width and timeout constants.
REQ-029 The timeout counter SHALL be the sub-module cc_membus_timeout_cnt, instantiated only under CC_MEMBUS_TIMEOUT_EN.
REQ-030 The existing 64-to-32 writeback mux SHALL stay external, driven by mux_rd_sel and mem_data_out.

Verification
REQ-031 ALU op, op_is_load=0, rd=5: wb_en=1, mux_rd_sel=0, wb_index=5 exactly one cycle after acceptance.
REQ-032 Load, addr=0x100, ack after 3 cycles with data 0xDEADBEEF: mem_rd_req high 3 cycles; next cycle wb_en=1, mux_rd_sel=1, mem_data_out=0xDEADBEEF.
REQ-033 Load with ack in the same cycle as the request: writeback on the following cycle; a spurious ack in IDLE causes no change.
REQ-034 Macro on, TIMEOUT_CYCLES=4, no ack: timeout_err pulses one cycle, no wb_en, and op_ready=1 after.
REQ-035 Reset asserted mid MEM_REQ: all outputs 0 asynchronously, and a subsequent ALU op completes normally.
